lcd_ctrl: RTL

HD44780-compatible character LCD controller that sits directly downstream of the single-cycle MCU's LCD output port. Software-side writes arrive as command/data requests over a valid/ready handshake and are buffered in a small FIFO. The block generates the power-on initialization sequence and the panel bus timing (setup, enable pulse, hold, execution wait), then drives the LCD pins. Write-only: RW is held low, and the busy flag is never read from the panel.

---
 rtl/lcd_ctrl.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/lcd_ctrl.sv
// HD44780-style character LCD controller: request FIFO, power-on init sequence,
// and write-only panel bus timing (setup, enable pulse, hold, execution wait).
module lcd_ctrl #(
    parameter int DEPTH  = 4,
    parameter int T_PWR  = 750000,
    parameter int T_SU   = 3,
    parameter int T_EN   = 15,
    parameter int T_H    = 3,
    parameter int T_EXEC = 2500,
    parameter int T_CLR  = 100000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       req_valid_i,
    input  logic       req_rs_i,
    input  logic [7:0] req_data_i,
    output logic       req_ready_o,
    output logic       init_done_o,
    output logic       busy_o,
    output logic       lcd_on_o,
    output logic       lcd_rs_o,
    output logic       lcd_rw_o,
    output logic       lcd_en_o,
    output logic [7:0] lcd_data_o
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PW    = AW + 1;
    localparam int T_MAX = (T_PWR > T_CLR) ? T_PWR : T_CLR;
    localparam int CW    = $clog2(T_MAX + 1);

    localparam logic [CW-1:0] LD_PWR  = CW'(T_PWR - 1);
    localparam logic [CW-1:0] LD_SU   = CW'(T_SU - 1);
    localparam logic [CW-1:0] LD_EN   = CW'(T_EN - 1);
    localparam logic [CW-1:0] LD_H    = CW'(T_H - 1);
    localparam logic [CW-1:0] LD_EXEC = CW'(T_EXEC - 1);
    localparam logic [CW-1:0] LD_CLR  = CW'(T_CLR - 1);

    typedef enum logic [2:0] {
        PWR_WAIT, INIT, SETUP, EN_HI, HOLD, EXEC, IDLE
    } state_t;

    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: init_byte = 8'h38;
            3'd3:             init_byte = 8'h0C;
            3'd4:             init_byte = 8'h01;
            default:          init_byte = 8'h06;
        endcase
    endfunction

    // Clear display / return home need the long execution wait.
    function automatic logic is_clr(input logic rs, input logic [7:0] d);
        is_clr = !rs && (d == 8'h01 || d == 8'h02 || d == 8'h03);
    endfunction

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [8:0]    mem [DEPTH];
    logic          full, empty, push, pop;
    logic [8:0]    head;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          cnt_done;
    logic [2:0]    rom_idx;
    logic          stg_vld, stg_rs;
    logic [7:0]    stg_data;

    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign push     = req_valid_i && !full;
    assign head     = mem[rd_ptr[AW-1:0]];
    assign cnt_done = (cnt == '0);

    assign req_ready_o = !full;
    assign busy_o      = (state != IDLE) || !empty || stg_vld;
    assign lcd_on_o    = 1'b1;
    assign lcd_rw_o    = 1'b0;

    // From IDLE the head is staged first; after an EXEC it loads straight onto the bus.
    always_comb begin
        pop = 1'b0;
        if (!empty) begin
            if (state == IDLE && !stg_vld)
                pop = 1'b1;
            else if (state == EXEC && cnt_done && init_done_o)
                pop = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= {req_rs_i, req_data_i};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= PWR_WAIT;
            cnt         <= LD_PWR;
            rom_idx     <= 3'd0;
            init_done_o <= 1'b0;
            lcd_en_o    <= 1'b0;
            lcd_rs_o    <= 1'b0;
            lcd_data_o  <= 8'h00;
            stg_vld     <= 1'b0;
            stg_rs      <= 1'b0;
            stg_data    <= 8'h00;
        end else begin
            case (state)
                PWR_WAIT: begin
                    if (cnt_done) begin
                        state <= INIT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                INIT: begin
                    lcd_rs_o   <= 1'b0;
                    lcd_data_o <= init_byte(rom_idx);
                    state      <= SETUP;
                    cnt        <= LD_SU;
                end
                SETUP: begin
                    if (cnt_done) begin
                        state    <= EN_HI;
                        lcd_en_o <= 1'b1;
                        cnt      <= LD_EN;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                EN_HI: begin
                    if (cnt_done) begin
                        state    <= HOLD;
                        lcd_en_o <= 1'b0;
                        cnt      <= LD_H;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                HOLD: begin
                    if (cnt_done) begin
                        state <= EXEC;
                        cnt   <= is_clr(lcd_rs_o, lcd_data_o) ? LD_CLR : LD_EXEC;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                EXEC: begin
                    if (!cnt_done) begin
                        cnt <= cnt - CW'(1);
                    end else if (!init_done_o) begin
                        if (rom_idx == 3'd5) begin
                            init_done_o <= 1'b1;
                            state       <= IDLE;
                            cnt         <= '0;
                        end else begin
                            rom_idx    <= rom_idx + 3'd1;
                            lcd_rs_o   <= 1'b0;
                            lcd_data_o <= init_byte(rom_idx + 3'd1);
                            state      <= SETUP;
                            cnt        <= LD_SU;
                        end
                    end else if (pop) begin
                        {lcd_rs_o, lcd_data_o} <= head;
                        state <= SETUP;
                        cnt   <= LD_SU;
                    end else begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end
                IDLE: begin
                    if (stg_vld) begin
                        lcd_rs_o   <= stg_rs;
                        lcd_data_o <= stg_data;
                        stg_vld    <= 1'b0;
                        state      <= SETUP;
                        cnt        <= LD_SU;
                    end else if (pop) begin
                        {stg_rs, stg_data} <= head;
                        stg_vld <= 1'b1;
                    end
                end
                default: begin
                    state <= PWR_WAIT;
                    cnt   <= LD_PWR;
                end
            endcase
        end
    end

endmodule
